// File: rtl/uart_pkg.sv
// Shared UART definitions: default line settings, divisor helpers and the
// receiver state encoding. Both the receiver and the transmitter import this.
package uart_pkg;

  localparam int DEFAULT_CLOCK_FREQUENCY = 27000000;
  localparam int DEFAULT_BAUD_RATE       = 115200;

  // Clock cycles per serial bit (integer division, 234 at the defaults).
  function automatic int baud_divisor(input int clock_frequency, input int baud_rate);
    return clock_frequency / baud_rate;
  endfunction

  // Clock cycles from the start-bit edge to the start-bit centre.
  function automatic int half_divisor(input int clock_frequency, input int baud_rate);
    return baud_divisor(clock_frequency, baud_rate) / 2;
  endfunction

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable
// reset value so an idle-high line does not look like an edge out of reset.
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; q is safe to use in the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. A falling edge of the synchronized line starts a frame;
// the start bit is confirmed at its centre, then data and stop bits are
// sampled one bit time apart at their centres.
//
// Output handshake: data/valid follow valid/ready semantics. Once valid is
// high, data stays stable until a cycle with ready=1; that cycle is the
// transfer and valid drops on the next edge unless a new byte lands in the
// same cycle, in which case data is replaced and valid stays high. A byte
// that completes while valid=1 and ready=0 is dropped and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = DEFAULT_CLOCK_FREQUENCY,
  parameter int BAUD_RATE       = DEFAULT_BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_error,
  output logic       overrun,
  output logic [1:0] state_dbg
);

  localparam int BAUD_DIVISOR = baud_divisor(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int HALF_DIVISOR = half_divisor(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int CNT_W        = $clog2(BAUD_DIVISOR);

  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_DIVISOR - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIVISOR - 1);

  logic             rx_s;
  logic             rx_s_d;
  rx_state_t        state;
  rx_state_t        state_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;

  logic fall;
  logic full_tick;
  logic half_tick;
  logic cnt_clr;
  logic shift_en;
  logic byte_done;
  logic frame_bad;

  sync_2ff #(
    .RESET_VALUE(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rx_s)
  );

  // A held-low line never shows a 1->0 transition, so after a break the
  // line must return high before another start bit can be detected.
  assign fall      = rx_s_d & ~rx_s;
  assign full_tick = (cnt == FULL_LAST);
  assign half_tick = (cnt == HALF_LAST);
  assign state_dbg = state;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RX_IDLE;
    else        state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      RX_IDLE:  if (fall) state_next = RX_START;
      RX_START: if (half_tick) state_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (full_tick && (bit_idx == 3'd7)) state_next = RX_STOP;
      RX_STOP:  if (full_tick) state_next = RX_IDLE;
      default:  state_next = RX_IDLE;
    endcase
  end

  // Per-state strobes for the datapath.
  always_comb begin
    cnt_clr   = (state == RX_IDLE) || (state_next != state) ||
                ((state == RX_DATA) && full_tick);
    shift_en  = (state == RX_DATA) && full_tick;
    byte_done = (state == RX_STOP) && full_tick && rx_s;
    frame_bad = (state == RX_STOP) && full_tick && !rx_s;
  end

  // Previous synchronized line value, for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_s_d <= 1'b1;
    else        rx_s_d <= rx_s;
  end

  // Cycle counter within the current bit period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt <= '0;
    else if (cnt_clr) cnt <= '0;
    else              cnt <= cnt + CNT_W'(1);
  end

  // Data bit index and LSB-first shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
    end else if (state != RX_DATA) begin
      bit_idx   <= 3'd0;
    end else if (shift_en) begin
      bit_idx   <= bit_idx + 3'd1;
      shift_reg <= {rx_s, shift_reg[7:1]};
    end
  end

  // Output holding register, handshake and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data        <= 8'h00;
      valid       <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_error <= frame_bad;
      overrun     <= byte_done && valid && !ready;
      if (byte_done && (!valid || ready)) begin
        data  <= shift_reg;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at the default 27 MHz / 115200 baud settings.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BIT  = 234;
  localparam int HALF = 117;
  // Posedges from the rx falling edge to valid rising: 2 synchronizer flops,
  // 1 edge-detect cycle, HALF in START, 8 data bits and the stop bit.
  localparam int RISE_LAT = 3 + HALF + 9 * BIT;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_error;
  logic       overrun;
  logic [1:0] state_dbg;

  int checks;
  int errors;
  int cyc;
  int valid_cycles;
  int fe_cnt;
  int ov_cnt;
  int rise_cyc;
  int last_start;
  logic prev_valid;
  logic [7:0] exp_q[$];

  uart_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .frame_error(frame_error),
    .overrun    (overrun),
    .state_dbg  (state_dbg)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: counts pulses and scores every accepted byte.
  initial begin
    valid_cycles = 0;
    fe_cnt       = 0;
    ov_cnt       = 0;
    rise_cyc     = -1;
    prev_valid   = 1'b0;
  end
  always @(negedge clk) begin
    if (valid) valid_cycles++;
    if (valid && !prev_valid) rise_cyc = cyc;
    prev_valid = valid;
    if (frame_error) fe_cnt++;
    if (overrun) ov_cnt++;
    if (rst_n && valid && ready) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_byte observed=%0h expected=none", data);
      end
      if (exp_q.size() > 0) check("rx_data", {24'd0, data}, {24'd0, exp_q.pop_front()});
    end
  end

  // Driver tasks: every input change happens 1 time unit after a posedge.
  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    last_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  task automatic idle_cycles(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    int v0, fe0, ov0, g0;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    rx     = 1'b1;
    ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_data", {24'd0, data}, 32'h00);
    check("reset_frame_error", {31'd0, frame_error}, 32'd0);
    check("reset_overrun", {31'd0, overrun}, 32'd0);
    check("reset_state", {30'd0, state_dbg}, {30'd0, RX_IDLE});
    rst_n = 1'b1;
    idle_cycles(10);

    // Single byte with ready high: one valid cycle at the expected time.
    ready = 1'b1;
    v0 = valid_cycles;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    idle_cycles(20);
    check("x55_rise_cycle", rise_cyc, last_start + RISE_LAT);
    check("x55_valid_cycles", valid_cycles - v0, 1);
    check("x55_scored", exp_q.size(), 0);

    // Short low glitch: detected as a start, rejected at the half-bit sample.
    v0 = valid_cycles;
    fe0 = fe_cnt;
    g0 = cyc;
    rx = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check("glitch_in_start", {30'd0, state_dbg}, {30'd0, RX_START});
    rx = 1'b1;
    repeat (g0 + 121 - cyc) @(posedge clk);
    #1;
    check("glitch_back_idle", {30'd0, state_dbg}, {30'd0, RX_IDLE});
    idle_cycles(BIT);
    check("glitch_no_valid", valid_cycles - v0, 0);
    check("glitch_no_frame_error", fe_cnt - fe0, 0);

    // Bad stop bit followed by a held break, then a good byte.
    v0 = valid_cycles;
    fe0 = fe_cnt;
    send_frame(8'hA5, 1'b0);
    rx = 1'b0;
    repeat (3 * BIT) @(posedge clk);
    #1;
    idle_cycles(BIT);
    check("break_one_frame_error", fe_cnt - fe0, 1);
    check("break_no_valid", valid_cycles - v0, 0);
    check("break_data_kept", {24'd0, data}, 32'h55);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    idle_cycles(20);
    check("after_break_scored", exp_q.size(), 0);
    check("after_break_data", {24'd0, data}, 32'h3C);

    // Back-to-back bytes with ready low: first held, second dropped.
    ready = 1'b0;
    ov0 = ov_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle_cycles(10);
    check("ovr_valid_held", {31'd0, valid}, 32'd1);
    check("ovr_data_held", {24'd0, data}, 32'hA5);
    check("ovr_one_pulse", ov_cnt - ov0, 1);
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    @(negedge clk);
    check("ovr_valid_cleared", {31'd0, valid}, 32'd0);
    check("ovr_scored", exp_q.size(), 0);
    ready = 1'b1;
    idle_cycles(10);

    // Reset during bit 4 of 0xFF, then a clean 0x81.
    v0 = valid_cycles;
    fe0 = fe_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rx = 1'b1;
    repeat (HALF) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midreset_state", {30'd0, state_dbg}, {30'd0, RX_IDLE});
    rst_n = 1'b1;
    idle_cycles(5 * BIT);
    check("midreset_no_valid", valid_cycles - v0, 0);
    check("midreset_no_frame_error", fe_cnt - fe0, 0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    idle_cycles(20);
    check("x81_rise_cycle", rise_cyc, last_start + RISE_LAT);
    check("x81_valid_cycles", valid_cycles - v0, 1);
    check("x81_scored", exp_q.size(), 0);

    // 0x00 then 0xFF with zero idle gap.
    v0 = valid_cycles;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle_cycles(20);
    check("b2b_valid_cycles", valid_cycles - v0, 2);
    check("b2b_no_frame_error", fe_cnt - fe0, 0);
    check("b2b_no_overrun", ov_cnt - ov0, 0);
    check("b2b_scored", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
